seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
- Iterative unsigned restoring divider: 8-bit dividend / 4-bit divisor, yielding 8-bit quotient and 4-bit remainder.
- Arithmetic inverse of the team's 4x4 array multiplier; shares its operand widths.
- Produces one quotient bit per clock, using a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath and is driven by a control FSM or testbench.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width; also the number of CALC iterations.
- DIVISOR_W, 4, divisor and remainder width.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  DIVIDEND_W  unsigned dividend; captured on accepted start.
- divisor  input  DIVISOR_W  unsigned divisor; captured on accepted start.
- busy  output  1  high while state=CALC.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  DIVIDEND_W  registered quotient.
- remainder  output  DIVISOR_W  registered remainder.
- div_by_zero  output  1  registered flag, updated together with done.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset: asserting rst_n=0 at any time, including mid-operation, forces:
  - state=IDLE;
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0;
  - internal shift, partial-remainder and count registers cleared.
  - An in-flight division is discarded and no done is produced.
- States:
  - IDLE: wait for start.
  - CALC: iterate.
  - DONE: one cycle, done=1.
- Start acceptance: start is accepted on an edge where state is IDLE or DONE. Back-to-back operations therefore give a done pulse every DIVIDEND_W+1 cycles.
- start while busy=1 is ignored: no effect on operands or counter.
- Accepted start, divisor!=0:
  - latch operands;
  - partial remainder (DIVISOR_W+1 bits) = 0;
  - count = DIVIDEND_W;
  - go to CALC.
- Accepted start, divisor==0: go directly to DONE with quotient=all ones (8'hFF), remainder=0, div_by_zero=1.
- CALC step, once per edge:
  - shift {partial remainder, dividend shift reg} left by 1;
  - trial = partial remainder − divisor, computed DIVISOR_W+1 bits wide;
  - if trial is non-negative, partial remainder = trial and shift in quotient bit 1;
  - otherwise restore and shift in 0;
  - decrement count.
- CALC completion: the edge that performs the final step (count 1→0) also:
  - loads the quotient and remainder outputs;
  - clears div_by_zero;
  - enters DONE.
- Latency: done is high in the cycle following the DIVIDEND_W-th edge after the start-sampling edge, i.e. 8 cycles. For divide-by-zero it is 1 cycle.
- DONE: done=1 for exactly one cycle. The next edge goes to IDLE, or to CALC/DONE if start is accepted on that edge.
- Outputs hold: quotient, remainder and div_by_zero keep their values until the next done; they do not change during CALC.
- Result invariant: quotient*divisor + remainder == dividend, with remainder < divisor, for every divisor != 0.

Optional Feature:
- Macro: DIVIDER_ZERO_SKIP_EN.
- Defined: on an accepted start with divisor!=0 and dividend < divisor:
  - skip CALC and enter DONE on the next edge;
  - quotient=0, remainder=dividend[DIVISOR_W-1:0], div_by_zero=0;
  - latency 1.
- Undefined: every nonzero-divisor operation takes the full DIVIDEND_W CALC cycles, with an identical numeric result.

Test Plan:
- 200 / 7 → quotient=28, remainder=4, div_by_zero=0; done high exactly 8 cycles after the start edge; busy=1 for those 8 cycles.
- 255 / 15 → quotient=17, remainder=0; followed by back-to-back 9 / 2 with start asserted in the DONE cycle → quotient=4, remainder=1, next done 9 cycles later.
- 100 / 0 → div_by_zero=1, quotient=8'hFF, remainder=0; done 1 cycle after start; busy never asserted.
- start 200/7, then start pulsed with 50/3 at cycle 3 → second request ignored; result 28 r4 at cycle 8; no second done.
- start 200/7, rst_n=0 at cycle 4 (asynchronous, mid-cycle) → all outputs 0 immediately, state IDLE; a fresh 13/4 afterwards gives 3 r1 at normal latency.
- 5 / 9 → quotient=0, remainder=5; done at 1 cycle with DIVIDER_ZERO_SKIP_EN defined, at 8 cycles without it.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider producing one quotient bit per clock, with a start/busy/done handshake.
// Define DIVIDER_ZERO_SKIP_EN to finish in one cycle when dividend < divisor.
module seq_restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic [DIVIDEND_W-1:0] shift_q, shift_d;
  logic [DIVISOR_W-1:0]  prem_q, prem_d;
  logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    pr_sh;
  logic [DIVISOR_W:0]    trial;
  logic                  qbit;
  logic [DIVISOR_W-1:0]  pr_next;
  logic [DIVIDEND_W-1:0] sh_next;

  // The stored partial remainder is always < divisor, so the shifted value
  // fits DIVISOR_W+1 bits and the trial's MSB is a true sign bit.
  always_comb begin
    pr_sh   = {prem_q, shift_q[DIVIDEND_W-1]};
    trial   = pr_sh - {1'b0, dvsr_q};
    qbit    = ~trial[DIVISOR_W];
    pr_next = qbit ? trial[DIVISOR_W-1:0] : pr_sh[DIVISOR_W-1:0];
    sh_next = {shift_q[DIVIDEND_W-2:0], qbit};
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    prem_d  = prem_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
`ifdef DIVIDER_ZERO_SKIP_EN
          else if (dividend < DIVIDEND_W'(divisor)) begin
            quot_d  = '0;
            rem_d   = dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b0;
            state_d = DONE;
          end
`endif
          else begin
            shift_d = dividend;
            dvsr_d  = divisor;
            prem_d  = '0;
            cnt_d   = CNT_W'(DIVIDEND_W);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        shift_d = sh_next;
        prem_d  = pr_next;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quot_d  = sh_next;
          rem_d   = pr_next;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      prem_q  <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      prem_q  <= prem_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: stimulus pushes hand-computed results, a negedge monitor checks each done.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  seq_restoring_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int r;
    int dbz;
    int cyc;
    int busy_n;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   busy_run = 0;
  int   held_q = 0;

`ifdef DIVIDER_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic issue(input int dvd, input int dvs, input int q, input int r,
                       input int dbz, input bit fast);
    exp_t e;
    dividend = 8'(dvd);
    divisor  = 4'(dvs);
    start    = 1'b1;
    e.q = q; e.r = r; e.dbz = dbz;
    e.cyc    = fast ? cyc + 1 : cyc + 9;
    e.busy_n = fast ? 0 : 8;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL done_timeout: no done within 20 cycles (cycle %0d)", cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
      held_q   = 0;
    end else begin
      if (busy) begin
        busy_run++;
        chk("hold_quotient", int'(quotient), held_q);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL spurious_done: done=1 with no request outstanding (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("quotient", int'(quotient), e.q);
          chk("remainder", int'(remainder), e.r);
          chk("div_by_zero", int'(div_by_zero), e.dbz);
          chk("done_cycle", cyc, e.cyc);
          chk("busy_cycles", busy_run, e.busy_n);
        end
        held_q   = int'(quotient);
        busy_run = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(200, 7, 28, 4, 0, 1'b0);   wait_done(); @(negedge clk);
    issue(255, 15, 17, 0, 0, 1'b0);  wait_done();
    issue(9, 2, 4, 1, 0, 1'b0);      wait_done(); @(negedge clk);
    issue(100, 0, 255, 0, 1, 1'b1);  wait_done(); @(negedge clk);
    issue(250, 13, 19, 3, 0, 1'b0);  wait_done(); @(negedge clk);
    issue(255, 1, 255, 0, 0, 1'b0);  wait_done(); @(negedge clk);
    issue(0, 5, 0, 0, 0, SKIP);      wait_done(); @(negedge clk);
    issue(5, 9, 0, 5, 0, SKIP);      wait_done(); @(negedge clk);

    // A start pulsed mid-calculation must be ignored.
    issue(200, 7, 28, 4, 0, 1'b0);
    @(negedge clk);
    dividend = 8'd50; divisor = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (12) @(negedge clk);

    // Asynchronous reset mid-calculation discards the operation.
    issue(200, 7, 28, 4, 0, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_quotient", int'(quotient), 0);
    chk("arst_remainder", int'(remainder), 0);
    chk("arst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    issue(13, 4, 3, 1, 0, 1'b0);     wait_done();

    repeat (12) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
